// File: rtl/score_disp_mux.sv
// rtl/score_disp_mux.sv - three-digit multiplexed seven-segment score display driver
//
// Purpose: scans hundreds/tens/ones BCD digits onto a 4-anode common-anode
// display (active-low anodes and segments). Digits are snapshotted at every
// frame wrap so a score change never tears mid-frame. Supports whole-display
// blinking and, optionally, leading-zero blanking.
//
// Optional feature macro: LEAD_ZERO_BLANK_EN (blank leading zeros on digits 2 and 1)
//
// Parameters:
//   N  refresh counter width; frame = 2^N clocks, each of 4 phases = 2^(N-2) clocks
//   F  frame counter width; blink half-period = 2^(F-1) frames
//
// Ports:
//   clk    in   1  system clock
//   reset  in   1  asynchronous active-high reset
//   bcd2   in   4  hundreds digit
//   bcd1   in   4  tens digit
//   bcd0   in   4  ones digit
//   blink  in   1  1 = blink whole display, 0 = steady
//   an     out  4  anode enables, active-low, an[0] = rightmost digit
//   sseg   out  8  segments, active-low, {dp,g,f,e,d,c,b,a}

module score_disp_mux #(
    parameter int N = 18,
    parameter int F = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] bcd2,
    input  logic [3:0] bcd1,
    input  logic [3:0] bcd0,
    input  logic       blink,
    output logic [3:0] an,
    output logic [7:0] sseg
);

    localparam logic [N-1:0] CNT_ONE  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [F-1:0] FCNT_ONE = {{(F-1){1'b0}}, 1'b1};

    logic [N-1:0] cnt_q, cnt_d;
    logic [F-1:0] fcnt_q, fcnt_d;
    logic [3:0]   sh2_q, sh1_q, sh0_q;
    logic [3:0]   an_q, an_d;
    logic [7:0]   sseg_q, sseg_d;

    logic [1:0]   phase;
    logic         frame_wrap;
    logic         blank;
    logic         digit_on;
    logic [3:0]   digit_val;

    // Active-low gfedcba; anything outside 0-9 shows a lone dash (g lit).
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    assign phase      = cnt_q[N-1 -: 2];
    assign frame_wrap = &cnt_q;
    assign blank      = blink & fcnt_q[F-1];

    assign cnt_d  = cnt_q + CNT_ONE;
    assign fcnt_d = frame_wrap ? fcnt_q + FCNT_ONE : fcnt_q;

    // Per-phase digit selection and lit/unlit decision. Phase 3 is dead time.
    always_comb begin
        digit_val = 4'd0;
        digit_on  = 1'b0;
        case (phase)
            2'd0: begin
                digit_val = sh0_q;
                digit_on  = 1'b1;
            end
            2'd1: begin
                digit_val = sh1_q;
`ifdef LEAD_ZERO_BLANK_EN
                // Tens is a leading zero only when hundreds is also zero;
                // dash codes are non-zero and therefore always shown.
                digit_on  = (sh2_q != 4'd0) || (sh1_q != 4'd0);
`else
                digit_on  = 1'b1;
`endif
            end
            2'd2: begin
                digit_val = sh2_q;
`ifdef LEAD_ZERO_BLANK_EN
                digit_on  = (sh2_q != 4'd0);
`else
                digit_on  = 1'b1;
`endif
            end
            default: begin
                digit_val = 4'd0;
                digit_on  = 1'b0;
            end
        endcase
    end

    always_comb begin
        an_d   = 4'b1111;
        sseg_d = 8'hFF;
        if (!blank && digit_on) begin
            an_d   = ~(4'b0001 << phase);
            sseg_d = {1'b1, seg_decode(digit_val)};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            fcnt_q <= '0;
            sh2_q  <= 4'd0;
            sh1_q  <= 4'd0;
            sh0_q  <= 4'd0;
            an_q   <= 4'b1111;
            sseg_q <= 8'hFF;
        end else begin
            cnt_q  <= cnt_d;
            fcnt_q <= fcnt_d;
            an_q   <= an_d;
            sseg_q <= sseg_d;
            // Snapshot only at the frame wrap; mid-frame input changes are ignored.
            if (frame_wrap) begin
                sh2_q <= bcd2;
                sh1_q <= bcd1;
                sh0_q <= bcd0;
            end
        end
    end

    assign an   = an_q;
    assign sseg = sseg_q;

endmodule

// File: tb/tb_score_disp_mux.sv
// tb/tb_score_disp_mux.sv - self-checking bench for score_disp_mux (N=4, F=2)

module tb_score_disp_mux;

    localparam int FRAME = 16;
`ifdef LEAD_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [3:0] bcd2, bcd1, bcd0;
    logic       blink;
    logic [3:0] an;
    logic [7:0] sseg;

    int vectors = 0;
    int misses  = 0;
    int k       = 0;

    score_disp_mux #(.N(4), .F(2)) dut (
        .clk  (clk),
        .reset(reset),
        .bcd2 (bcd2),
        .bcd1 (bcd1),
        .bcd0 (bcd0),
        .blink(blink),
        .an   (an),
        .sseg (sseg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: position in frame, frame index and the digits
    // sampled at the last frame end determine what the display must show.
    int         m_pos;
    int         m_frame;
    logic [3:0] m_sh [3];
    logic [3:0] exp_an;
    logic [7:0] exp_sseg;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] tbl [10];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        if (d > 4'd9) return 7'h3F;
        return tbl[d];
    endfunction

    function automatic bit lit(input int pos, input int frame, input logic bl);
        int ph;
        ph = pos / 4;
        if (bl && ((frame % 4) >= 2)) return 1'b0;
        if (ph == 3) return 1'b0;
        if (LZB && ph == 2 && m_sh[2] == 4'd0) return 1'b0;
        if (LZB && ph == 1 && m_sh[2] == 4'd0 && m_sh[1] == 4'd0) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pos    <= 0;
            m_frame  <= 0;
            m_sh[0]  <= 4'd0;
            m_sh[1]  <= 4'd0;
            m_sh[2]  <= 4'd0;
            exp_an   <= 4'hF;
            exp_sseg <= 8'hFF;
        end else begin
            if (lit(m_pos, m_frame, blink)) begin
                exp_an   <= ~(4'b0001 << (m_pos / 4));
                exp_sseg <= {1'b1, seg_of(m_sh[m_pos / 4])};
            end else begin
                exp_an   <= 4'hF;
                exp_sseg <= 8'hFF;
            end
            if (m_pos == FRAME - 1) begin
                m_sh[0] <= bcd0;
                m_sh[1] <= bcd1;
                m_sh[2] <= bcd2;
                m_frame <= (m_frame + 1) % 4;
            end
            m_pos <= (m_pos + 1) % FRAME;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                vectors++;
                if (an !== exp_an || sseg !== exp_sseg) begin
                    misses++;
                    $display("FAIL model k=%0d: an=%b sseg=%h, want an=%b sseg=%h",
                             k, an, sseg, exp_an, exp_sseg);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] want);
        vectors++;
        if (act !== want) begin
            misses++;
            $display("FAIL %s k=%0d: got %h, want %h", nm, k, act, want);
        end
    endtask

    task automatic run_to(input int target);
        while (k < target) begin
            @(posedge clk);
            k++;
        end
        #1;
    endtask

    task automatic expect_out(input string nm, input logic [3:0] a, input logic [7:0] s);
        chk({nm, ".an"}, {4'h0, an}, {4'h0, a});
        chk({nm, ".sseg"}, sseg, s);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bcd2  = 4'd2;
        bcd1  = 4'd4;
        bcd0  = 4'd7;
        blink = 1'b0;
        #3;
        expect_out("reset", 4'hF, 8'hFF);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        k = 0;

        // Frame 1 shows the reset shadows
        run_to(1);  expect_out("f1_d0", 4'hE, 8'hC0);
        run_to(5);  expect_out("f1_d1", LZB ? 4'hF : 4'hD, LZB ? 8'hFF : 8'hC0);
        run_to(9);  expect_out("f1_d2", LZB ? 4'hF : 4'hB, LZB ? 8'hFF : 8'hC0);
        run_to(13); expect_out("f1_dead", 4'hF, 8'hFF);

        // Frame 2 shows 2/4/7
        run_to(17); expect_out("f2_d0", 4'hE, 8'hF8);
        run_to(21); expect_out("f2_d1", 4'hD, 8'h99);
        run_to(25); expect_out("f2_d2", 4'hB, 8'hA4);
        run_to(29); expect_out("f2_dead", 4'hF, 8'hFF);

        // Mid-frame change of ones digit at cycle 6 of frame 3
        run_to(34); expect_out("f3_d0", 4'hE, 8'hF8);
        run_to(38); bcd0 = 4'd3;
        run_to(41); expect_out("f3_d2", 4'hB, 8'hA4);
        run_to(49); expect_out("f4_d0", 4'hE, 8'hB0);

        // Illegal tens digit shows a dash
        run_to(50); bcd1 = 4'd12;
        run_to(69); expect_out("f5_dash", 4'hD, 8'hBF);
        run_to(73); expect_out("f5_d2", 4'hB, 8'hA4);

        // Leading zeros 0/0/5
        run_to(70 + 4); bcd2 = 4'd0; bcd1 = 4'd0; bcd0 = 4'd5;
        run_to(81); expect_out("z_d0", 4'hE, 8'h92);
        run_to(85); expect_out("z_d1", LZB ? 4'hF : 4'hD, LZB ? 8'hFF : 8'hC0);
        run_to(89); expect_out("z_d2", LZB ? 4'hF : 4'hB, LZB ? 8'hFF : 8'hC0);

        // Blink: frames with fcnt=2,3 blanked, fcnt=0 normal
        run_to(90); blink = 1'b1;
        run_to(93); expect_out("bl_fc1", 4'hF, 8'hFF);
        run_to(97); expect_out("bl_fc2", 4'hF, 8'hFF);
        run_to(113); expect_out("bl_fc3", 4'hF, 8'hFF);
        run_to(129); expect_out("bl_fc0", 4'hE, 8'h92);
        run_to(161); expect_out("bl_fc2b", 4'hF, 8'hFF);
        blink = 1'b0;
        run_to(162); expect_out("bl_off", 4'hE, 8'h92);

        // Reset at cycle 7 of a frame showing 2/4/7
        bcd2 = 4'd2; bcd1 = 4'd4; bcd0 = 4'd7;
        run_to(183); expect_out("pre_rst", 4'hD, 8'h99);
        reset = 1'b1;
        #1;
        expect_out("async_rst", 4'hF, 8'hFF);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        k = 0;
        run_to(1);  expect_out("rr_d0", 4'hE, 8'hC0);
        run_to(5);  expect_out("rr_d1", LZB ? 4'hF : 4'hD, LZB ? 8'hFF : 8'hC0);
        run_to(9);  expect_out("rr_d2", LZB ? 4'hF : 4'hB, LZB ? 8'hFF : 8'hC0);
        run_to(17); expect_out("rr_f2", 4'hE, 8'hF8);
        run_to(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
